mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus (`MemWrite`/`DataAdr`/`WriteData`/`ReadData`), alongside `dmem`. CPU stores to the TXDATA register enqueue a byte into a small FIFO; a bit-timing state machine serialises bytes onto `tx` as 8N1 frames, or 8E1 with parity enabled. A STATUS register is readable combinationally so the single-cycle core can poll it in the same cycle it issues the load.

---
 rtl/mmio_uart_pkg.sv | 27 ++
 rtl/mmio_uart_tx_if.sv | 23 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/mmio_uart_tx.sv | 214 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the TX FSM state type.
package mmio_uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_BUSY     = 2;
  localparam int unsigned ST_OVF      = 3;
  localparam int unsigned ST_CNT_LSB  = 4;
  localparam int unsigned ST_CNT_MSB  = 7;
  localparam int unsigned ST_PARITY   = 8;

  // STATUS write bit that clears the sticky overflow flag
  localparam int unsigned OVF_CLR_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by an MMIO responder.
interface mmio_uart_tx_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output ReadData
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head so a pop and the consumer's
// load of the head happen on the same edge. DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Status flags and head-of-queue read
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    rdata   = mem_q[rd_ptr_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. TXDATA at BASE+0 enqueues a byte, STATUS at
// BASE+4 is read combinationally. Frames are 8N1, or 8E1 when the macro
// MMIO_UART_PARITY_EN is defined.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef MMIO_UART_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic          wr_txdata, wr_status, sel_status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [3:0]    cnt_sat;
  logic [31:0]   status_word;
  logic          unused_wdata;

  logic          ovf_q, ovf_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last, load;
`ifdef MMIO_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign unused_wdata = ^bus.WriteData[31:8];

  // Full 32-bit address decode; misaligned addresses never match
  always_comb begin
    wr_txdata  = bus.MemWrite && (bus.DataAdr == BASE_ADDR + TXDATA_OFS);
    wr_status  = bus.MemWrite && (bus.DataAdr == BASE_ADDR + STATUS_OFS);
    sel_status = (bus.DataAdr == BASE_ADDR + STATUS_OFS);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (bus.WriteData[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: set by a store that finds the FIFO full before the edge
  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (wr_status && bus.WriteData[OVF_CLR_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  // STATUS word and combinational read mux
  always_comb begin
    cnt_sat     = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    status_word = '0;
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_BUSY]               = (state_q != S_IDLE);
    status_word[ST_OVF]                = ovf_q;
    status_word[ST_CNT_MSB:ST_CNT_LSB] = cnt_sat;
    status_word[ST_PARITY]             = PARITY_EN;
    bus.ReadData = sel_status ? status_word : '0;
  end

  // TX FSM next-state: tx_d is the line level for the state being entered,
  // so the registered output changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    baud_last = (baud_q == BAUD_LAST);
`ifdef MMIO_UART_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = !fifo_empty;
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
    // IDLE and end-of-STOP share the pop-and-start path
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  // TX FSM, datapath and overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a line receiver decodes frames from
// tx, and expectations come from byte queues and frame-timing arithmetic.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          C     = 16;
  localparam int          DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
  localparam int          NB      = 11;
  localparam logic [31:0] PAR_BIT = 32'h100;
`else
  localparam int          NB      = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tx;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .DEPTH        (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       framing_ok;
    logic       par;
  } frame_t;

  frame_t          rxq[$];
  logic [NB-1:0]   rx_bits;
  bit              rx_active = 1'b0;
  int              rx_cnt;
  int              rx_start;

  // Line receiver: samples mid-bit on falling clock edges, aborts on reset
  initial begin
    frame_t f;
    int     idx;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_start  = cyc;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= C / 2 && ((rx_cnt - C / 2) % C) == 0) begin
          idx          = (rx_cnt - C / 2) / C;
          rx_bits[idx] = tx;
          if (idx == NB - 1) begin
            f.data       = rx_bits[8:1];
            f.start      = rx_start;
            f.framing_ok = (rx_bits[0] === 1'b0) && (rx_bits[NB-1] === 1'b1);
            f.par        = rx_bits[9];
            rxq.push_back(f);
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-cycle store starting at a falling edge; k is the cycle count then
  task automatic store(input logic [31:0] adr, input logic [31:0] data, output int k);
    k = cyc;
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = adr;
    bus_if.WriteData = data;
    @(negedge clk);
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = BASE + 32'h4;
    bus_if.WriteData = '0;
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] v);
    bus_if.MemWrite = 1'b0;
    bus_if.DataAdr  = adr;
    #1;
    v = bus_if.ReadData;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rxq.size() < n; i++) @(negedge clk);
    check({tag, "_arrived"}, 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp, output int s);
    frame_t f;
    s = -1;
    if (rxq.size() > 0) begin
      f = rxq.pop_front();
      s = f.start;
      check({tag, "_data"}, 32'(f.data), 32'(exp));
      check({tag, "_framing"}, 32'(f.framing_ok), 32'd1);
`ifdef MMIO_UART_PARITY_EN
      check({tag, "_parity"}, 32'(f.par), 32'(^exp));
`endif
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] v;
    rd(BASE + 32'h4, v);
    for (int i = 0; i < budget && v[2] !== 1'b0; i++) begin
      @(negedge clk);
      rd(BASE + 32'h4, v);
    end
    check({tag, "_idle"}, 32'(v[2]), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b[8];
    int          k, k2, s, s1, s2, n, nexp;
    bit          low_seen;

    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = '0;
    bus_if.WriteData = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and address decode
    rd(BASE + 32'h4, v); check("reset_status", v, 32'h2 | PAR_BIT);
    rd(BASE, v);         check("txdata_reads_zero", v, 32'h0);
    rd(BASE + 32'h5, v); check("misaligned_reads_zero", v, 32'h0);
    rd(32'h0000_0004, v); check("other_addr_zero", v, 32'h0);
    low_seen = 1'b0;
    repeat (50) begin @(negedge clk); if (tx !== 1'b1) low_seen = 1'b1; end
    check("idle_tx_high", 32'(low_seen), 32'd0);

    // Single frame: latency, bit pattern, busy release
    store(BASE, 32'hFFFF_FF55, k);
    wait_rx("f55", 1, NB * C + 40);
    expect_frame("f55", 8'h55, s);
    check("f55_latency", 32'(s), 32'(k + 2));
    while (s >= 0 && cyc < s + NB * C - 1) @(negedge clk);
    rd(BASE + 32'h4, v); check("busy_last_stop_cycle", 32'(v[2]), 32'd1);
    @(negedge clk);
    rd(BASE + 32'h4, v); check("busy_dropped", v, 32'h2 | PAR_BIT);

    // Back-to-back frames
    store(BASE, 32'hA3, k);
    store(BASE, 32'h0F, k2);
    repeat (5) @(negedge clk);
    rd(BASE + 32'h4, v); check("count_one_in_flight", v, 32'h14 | PAR_BIT);
    wait_rx("b2b", 2, 2 * NB * C + 40);
    expect_frame("fA3", 8'hA3, s1);
    expect_frame("f0F", 8'h0F, s2);
    check("fA3_latency", 32'(s1), 32'(k + 2));
    check("b2b_no_gap", 32'(s2), 32'(s1 + NB * C));

    // Overflow: one in flight plus DEPTH queued, then a dropped byte
    wait_idle("pre_ovf", 4 * NB * C);
    for (int i = 0; i < DEPTH + 2; i++) b[i] = 8'($urandom);
    for (int i = 0; i < DEPTH + 2; i++) store(BASE, {24'h0, b[i]}, k);
    rd(BASE + 32'h4, v); check("ovf_full_status", v, 32'h4D | PAR_BIT);
    store(BASE + 32'h4, 32'hFFFF_FFF7, k);
    rd(BASE + 32'h4, v); check("ovf_kept_by_bit3_zero", v, 32'h4D | PAR_BIT);
    wait_rx("ovf", DEPTH + 1, (DEPTH + 1) * NB * C + 60);
    for (int i = 0; i < DEPTH + 1; i++) expect_frame($sformatf("ovf%0d", i), b[i], s);
    repeat (2 * NB * C) @(negedge clk);
    check("dropped_byte_absent", 32'(rxq.size()), 32'd0);
    rd(BASE + 32'h4, v); check("ovf_sticky_idle", v, 32'hA | PAR_BIT);
    store(BASE + 32'h4, 32'h8, k);
    rd(BASE + 32'h4, v); check("ovf_cleared", v, 32'h2 | PAR_BIT);

    // Random bursts: the first DEPTH+1 bytes of a burst from idle get through
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      n    = $urandom_range(1, DEPTH + 3);
      nexp = (n < DEPTH + 1) ? n : DEPTH + 1;
      for (int i = 0; i < n; i++) b[i] = 8'($urandom);
      for (int i = 0; i < n; i++) store(BASE, {24'h0, b[i]}, k);
      wait_rx($sformatf("rnd%0d", r), nexp, nexp * NB * C + 60);
      for (int i = 0; i < nexp; i++) expect_frame($sformatf("rnd%0d_%0d", r, i), b[i], s);
      repeat (NB * C + 20) @(negedge clk);
      check($sformatf("rnd%0d_no_extra", r), 32'(rxq.size()), 32'd0);
      rd(BASE + 32'h4, v);
      check($sformatf("rnd%0d_status", r), v,
            32'h2 | PAR_BIT | ((n > DEPTH + 1) ? 32'h8 : 32'h0));
      store(BASE + 32'h4, 32'h8, k);
    end

    // Reset in the middle of data bit 3 with bytes queued
    wait_idle("pre_reset", 4 * NB * C);
    store(BASE, 32'h5A, k);
    store(BASE, 32'hC3, k2);
    store(BASE, 32'h81, k2);
    while (cyc < k + 2 + C + 3 * C + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx_high", 32'(tx), 32'd1);
    rd(BASE + 32'h4, v); check("reset_mid_status", v, 32'h2 | PAR_BIT);
    reset = 1'b0;
    low_seen = 1'b0;
    repeat (3 * NB * C) begin @(negedge clk); if (tx !== 1'b1) low_seen = 1'b1; end
    check("no_frames_after_reset", 32'(low_seen), 32'd0);
    check("rx_empty_after_reset", 32'(rxq.size()), 32'd0);

`ifdef MMIO_UART_PARITY_EN
    // Parity frames: 8'h07 has odd weight, 8'h03 even
    store(BASE, 32'h07, k);
    wait_rx("p07", 1, NB * C + 40);
    expect_frame("p07", 8'h07, s);
    while (s >= 0 && cyc < s + 11 * C - 1) @(negedge clk);
    rd(BASE + 32'h4, v); check("p07_busy_last", 32'(v[2]), 32'd1);
    @(negedge clk);
    rd(BASE + 32'h4, v); check("p07_len_176", v, 32'h102);
    store(BASE, 32'h03, k);
    wait_rx("p03", 1, NB * C + 40);
    expect_frame("p03", 8'h03, s);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
